seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Parametrised N-digit multiplexed 7-segment display controller, successor to the fixed 4-digit scanner.
//  Time-multiplexes N hex digits onto shared cathodes. Adds double-buffered loading, per-digit decimal
//  point, PWM brightness, per-digit blink and leading-zero suppression. Sits between the vitals/alarm
//  formatting logic and the board anode/cathode pins.
// PARAMETERS
//  N_DIGITS     4   digits scanned (2..8)
//  SLOT_LOG2    16  digit slot length = 2**SLOT_LOG2 clk cycles
//  BRIGHT_W     3   brightness code width (2**BRIGHT_W levels)
//  BLINK_FRAMES 64  full scan frames per blink half-period (>=1)
//  ACTIVE_LOW   1   1: an/seg/dp_n pins active-low; 0: active-high
// PORTS
//  clk        in  1            system clock
//  rst        in  1            asynchronous active-high reset
//  load       in  1            capture digits/dp/blink_en/lz_supp into pending buffer
//  digits     in  4*N_DIGITS   hex digit k at [4k+3:4k]; k=0 rightmost
//  dp         in  N_DIGITS     decimal point per digit
//  blink_en   in  N_DIGITS     per-digit blink enable
//  lz_supp    in  1            leading-zero suppression enable
//  bright     in  BRIGHT_W     brightness, 0 = min duty, all-ones = full
//  an         out N_DIGITS     anode enables, one-hot-or-none
//  seg        out 7            cathodes, seg[0]=CA .. seg[6]=CG
//  dp_n       out 1            decimal point cathode
//  digit_idx  out $clog2(N_DIGITS)  digit currently driven
//  frame_done out 1            1-cycle pulse at end of last digit slot
// BEHAVIOUR
//  - Reset (async, any time): an/seg/dp_n inactive, digit_idx=0, frame_done=0, slot counter=0,
//    frame counter=0, blink_phase=0, pending and active buffers cleared. Display blanks immediately.
//  - Slot counter runs 0..2**SLOT_LOG2-1 and wraps. On wrap, digit_idx advances; N_DIGITS-1 wraps to 0
//    and frame_done pulses in that same cycle.
//  - Double buffer: load=1 writes inputs to pending at the clk edge. At each frame wrap, active <=
//    pending. If load and frame wrap coincide, active gets the newly loaded values (forwarded).
//    Mid-frame loads never change the current frame.
//  - Brightness: lit = (slot_cnt[SLOT_LOG2-1 -: BRIGHT_W] <= bright) && (slot_cnt != 0).
//    slot_cnt==0 is a one-cycle ghost guard with all anodes off. bright=max gives full slot minus
//    1 cycle. bright=0 gives 1/2**BRIGHT_W duty. bright is sampled live, not buffered.
//  - Blink: frame counter counts frame wraps to BLINK_FRAMES-1, then wraps and toggles blink_phase.
//    Digit k is blanked while blink_phase=1 and active blink_en[k]=1.
//  - Leading-zero suppression (active lz_supp=1): scan from k=N_DIGITS-1 down. Digit k is suppressed
//    while it and all higher digits are 0. Digit 0 is never suppressed. A suppressed digit's cathodes
//    are off, but its dp is still shown.
//  - Decode: 0-F to standard hex glyphs (b, d lowercase). Blanked digit: seg off, an off, dp off.
//    Exception: suppressed digit keeps an on if dp=1.
//  - All outputs registered. Pins reflect slot_cnt/digit_idx with 1 cycle latency. digit_idx output is
//    aligned with an/seg.
//  - Polarity is applied only at the output registers. Internal logic is active-high.
// STRUCTURE
//  - Package seg7_pkg: SEG_BLANK constant, function hex_to_seg(logic [3:0]) -> logic [6:0] (active-high).
//  - One sub-module, seg7_lz_mask: combinational N-digit leading-zero mask from active digits.
//  - Counters, buffers, blink and output regs live in the top module.
// TESTING (SLOT_LOG2=4, BRIGHT_W=2, BLINK_FRAMES=2, N_DIGITS=4, ACTIVE_LOW=0 unless noted)
//  1. rst mid-scan with digit 2 lit -> same cycle an=0000, seg=0; after release digit_idx=0,
//     first an=0001 at cycle 2.
//  2. load digits=16'h1234, dp=0010, bright=3 -> from next frame an rotates 0001..1000 every 16
//     cycles. seg = glyphs 4,3,2,1. dp lit only with an=0010. an off on slot cycle 0.
//  3. bright=0 -> each anode high exactly 3 cycles (slot_cnt 1..3) per 16-cycle slot;
//     bright=1 -> 7 cycles.
//  4. lz_supp=1, digits=16'h0050, dp=0100 -> digit3 fully dark; digit2 an on, seg=0, dp on;
//     digits 1,0 show 5,0. digits=0000 -> only digit0 shows 0.
//  5. blink_en=0001 -> digit0 lit 2 frames, dark 2 frames, repeating. Other digits unaffected.
//  6. load pulsed in the same cycle as frame_done -> new value displayed on the very next frame.
//     load mid-frame -> old value held until frame wrap. frame_done pulses once per 64 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and glyph decode for the multiplexed 7-segment scanner.
// Glyphs are active-high; seg[0]=CA .. seg[6]=CG.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h3f;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5b;
      4'h3:    s = 7'h4f;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6d;
      4'h6:    s = 7'h7d;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7f;
      4'h9:    s = 7'h6f;
      4'ha:    s = 7'h77;
      4'hb:    s = 7'h7c;
      4'hc:    s = 7'h39;
      4'hd:    s = 7'h5e;
      4'he:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero mask: bit k set when digit k and every higher digit are zero.
// Digit 0 is never masked so a zero value still shows a single "0".
module seg7_lz_mask #(
  parameter int unsigned N_DIGITS = 4
) (
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic                  en,
  output logic [N_DIGITS-1:0]   mask
);

  always_comb begin
    logic zero_run;
    mask     = '0;
    zero_run = en;
    for (int k = int'(N_DIGITS) - 1; k >= 1; k--) begin
      zero_run = zero_run && (digits[4*k +: 4] == 4'h0);
      mask[k]  = zero_run;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment scanner with double-buffered loading, PWM brightness,
// per-digit blink and leading-zero suppression. All pins are registered.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SLOT_LOG2    = 16,
  parameter int unsigned BRIGHT_W     = 3,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [4*N_DIGITS-1:0]       digits,
  input  logic [N_DIGITS-1:0]         dp,
  input  logic [N_DIGITS-1:0]         blink_en,
  input  logic                        lz_supp,
  input  logic [BRIGHT_W-1:0]         bright,
  output logic [N_DIGITS-1:0]         an,
  output logic [6:0]                  seg,
  output logic                        dp_n,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_done
);

  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [FC_W-1:0]  LAST_FC  = FC_W'(BLINK_FRAMES - 1);
  localparam logic POL = ACTIVE_LOW;

  logic [SLOT_LOG2-1:0]  slot_q, slot_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic [FC_W-1:0]       fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;
  logic                  slot_wrap, frame_wrap;

  logic [4*N_DIGITS-1:0] pend_digits_q, act_digits_q;
  logic [N_DIGITS-1:0]   pend_dp_q, act_dp_q;
  logic [N_DIGITS-1:0]   pend_blink_q, act_blink_q;
  logic                  pend_lz_q, act_lz_q;
  logic [N_DIGITS-1:0]   lz_mask;

  logic [N_DIGITS-1:0]   an_d, an_q;
  logic [6:0]            seg_d, seg_q;
  logic                  dp_d, dp_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  fdone_q;

  assign slot_wrap  = &slot_q;
  assign frame_wrap = slot_wrap && (cur_q == LAST_IDX);

  // Scan and blink counters.
  always_comb begin
    slot_d  = slot_q + 1'b1;
    cur_d   = cur_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (slot_wrap) begin
      cur_d = frame_wrap ? '0 : cur_q + 1'b1;
    end
    if (frame_wrap) begin
      if (fcnt_q == LAST_FC) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q  <= '0;
      cur_q   <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      cur_q   <= cur_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  // A load coinciding with the frame wrap is forwarded straight into the active copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_blink_q  <= '0;
      pend_lz_q     <= 1'b0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_blink_q   <= '0;
      act_lz_q      <= 1'b0;
    end else begin
      if (load) begin
        pend_digits_q <= digits;
        pend_dp_q     <= dp;
        pend_blink_q  <= blink_en;
        pend_lz_q     <= lz_supp;
      end
      if (frame_wrap) begin
        act_digits_q <= load ? digits   : pend_digits_q;
        act_dp_q     <= load ? dp       : pend_dp_q;
        act_blink_q  <= load ? blink_en : pend_blink_q;
        act_lz_q     <= load ? lz_supp  : pend_lz_q;
      end
    end
  end

  seg7_lz_mask #(
    .N_DIGITS (N_DIGITS)
  ) u_lz_mask (
    .digits (act_digits_q),
    .en     (act_lz_q),
    .mask   (lz_mask)
  );

  always_comb begin
    logic [3:0]          cur_digit;
    logic                cur_dp, cur_blink, cur_sup, lit, show;
    logic [N_DIGITS-1:0] an_sel;
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_sup   = 1'b0;
    an_sel    = '0;
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      if (cur_q == IDX_W'(k)) begin
        cur_digit = act_digits_q[4*k +: 4];
        cur_dp    = act_dp_q[k];
        cur_blink = act_blink_q[k];
        cur_sup   = lz_mask[k];
        an_sel[k] = 1'b1;
      end
    end
    // Slot cycle 0 is a ghost guard so adjacent digits never overlap.
    lit   = (slot_q[SLOT_LOG2-1 -: BRIGHT_W] <= bright) && (slot_q != '0);
    show  = lit && !(phase_q && cur_blink) && (!cur_sup || cur_dp);
    an_d  = show ? an_sel : '0;
    seg_d = (show && !cur_sup) ? hex_to_seg(cur_digit) : SEG_BLANK;
    dp_d  = show && cur_dp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q    <= {N_DIGITS{POL}};
      seg_q   <= {7{POL}};
      dp_q    <= POL;
      idx_q   <= '0;
      fdone_q <= 1'b0;
    end else begin
      an_q    <= an_d ^ {N_DIGITS{POL}};
      seg_q   <= seg_d ^ {7{POL}};
      dp_q    <= dp_d ^ POL;
      idx_q   <= cur_q;
      fdone_q <= frame_wrap;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_q;
  assign digit_idx  = idx_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed and random loads checked every cycle against a
// time-indexed model (edge count -> slot, digit, frame, active load record).
module tb_seg7_scan_ctrl;

  localparam int N      = 4;
  localparam int SL     = 4;
  localparam int BW     = 2;
  localparam int BF     = 2;
  localparam int SLOT   = 1 << SL;
  localparam int FRAME  = SLOT * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blink_en = '0;
  logic        lz_supp = 1'b0;
  logic [1:0]  bright = 2'd3;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic [1:0]  digit_idx;
  logic        frame_done;

  seg7_scan_ctrl #(
    .N_DIGITS     (N),
    .SLOT_LOG2    (SL),
    .BRIGHT_W     (BW),
    .BLINK_FRAMES (BF),
    .ACTIVE_LOW   (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digits     (digits),
    .dp         (dp),
    .blink_en   (blink_en),
    .lz_supp    (lz_supp),
    .bright     (bright),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          e;
    logic [15:0] d;
    logic [3:0]  dpv;
    logic [3:0]  bl;
    logic        lz;
  } rec_t;

  rec_t  recs[$];
  int    e = 0;
  int    errors = 0;
  int    checks = 0;

  // Segment letters lit for each hex glyph.
  string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [31:0] glyph_bits(input int h);
    logic [31:0] r;
    string       s;
    r = '0;
    s = glyph[h];
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  // Pins after edge c+1 reflect the scan state reached after edge c.
  task automatic check_pins(input int c, input int b);
    int          f, slot, k, dv, nib;
    logic [15:0] d;
    logic [3:0]  dpv, bl;
    logic        lz, lit, sup, blank, show;
    logic [31:0] exp_an, exp_seg;
    f = c / FRAME;
    d = '0; dpv = '0; bl = '0; lz = 1'b0;
    foreach (recs[i]) begin
      if (recs[i].e <= f * FRAME) begin
        d = recs[i].d; dpv = recs[i].dpv; bl = recs[i].bl; lz = recs[i].lz;
      end
    end
    slot  = c % SLOT;
    k     = (c / SLOT) % N;
    dv    = int'(d);
    nib   = (dv >> (4 * k)) & 15;
    lit   = (slot / (SLOT >> BW) <= b) && (slot != 0);
    sup   = lz && (k != 0) && ((dv >> (4 * k)) == 0);
    blank = ((f / BF) % 2 == 1) && bl[k];
    show  = lit && !blank && (!sup || dpv[k]);
    exp_an  = show ? (32'd1 << k) : 32'd0;
    exp_seg = (show && !sup) ? glyph_bits(nib) : 32'd0;
    chk("an", 32'(an), exp_an);
    chk("seg", 32'(seg), exp_seg);
    chk("dp", 32'(dp_n), 32'(show && dpv[k]));
    chk("digit_idx", 32'(digit_idx), 32'(k));
    chk("frame_done", 32'(frame_done), 32'(c % FRAME == FRAME - 1));
  endtask

  task automatic tick();
    rec_t r;
    int   b;
    @(posedge clk);
    e++;
    b = int'(bright);
    if (load) begin
      r.e = e; r.d = digits; r.dpv = dp; r.bl = blink_en; r.lz = lz_supp;
      recs.push_back(r);
    end
    #1;
    check_pins(e - 1, b);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      load = 1'b0;
    end
  endtask

  task automatic put(input logic [15:0] d, input logic [3:0] p, input logic [3:0] bl,
                     input logic lz);
    load = 1'b1; digits = d; dp = p; blink_en = bl; lz_supp = lz;
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_an"}, 32'(an), 32'd0);
    chk({tag, "_seg"}, 32'(seg), 32'd0);
    chk({tag, "_dp"}, 32'(dp_n), 32'd0);
    chk({tag, "_fd"}, 32'(frame_done), 32'd0);
  endtask

  // Async reset between edges while digit 2 is lit; pins must blank at once.
  task automatic mid_reset();
    int guard = 0;
    while (!(((e - 1) / SLOT) % N == 2 && (e - 1) % SLOT == 6) && guard < 4 * FRAME) begin
      tick();
      load = 1'b0;
      guard++;
    end
    chk("reach_digit2", 32'(guard < 4 * FRAME), 32'd1);
    #2 rst = 1'b1;
    #1 check_dark("rst_async");
    chk("rst_idx", 32'(digit_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_dark("rst_hold");
    rst = 1'b0;
    e = 0;
    recs.delete();
  endtask

  task automatic drive_random();
    logic [15:0] d;
    bit          at_wrap;
    at_wrap = ((e + 1) % FRAME == 0);
    load = ($urandom_range(0, 15) == 0) || (at_wrap && $urandom_range(0, 1) == 1);
    if (load) begin
      for (int i = 0; i < 4; i++) d[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
      digits = d; dp = 4'($urandom); blink_en = 4'($urandom); lz_supp = 1'($urandom);
    end
    if ($urandom_range(0, 31) == 0) bright = 2'($urandom);
  endtask

  initial begin
    #1 check_dark("rst_init");
    #13 rst = 1'b0;
    e = 0;
    chk("post_rst_idx", 32'(digit_idx), 32'd0);
    // Hex display with dp on digit 1.
    bright = 2'd3;
    put(16'h1234, 4'b0010, 4'b0000, 1'b0);
    run(1);
    tick();
    chk("first_an", 32'(an), 32'd1);
    run(2 * FRAME);
    // PWM duty.
    bright = 2'd0;
    run(FRAME + 8);
    bright = 2'd1;
    run(FRAME + 8);
    bright = 2'd3;
    // Leading-zero suppression.
    put(16'h0050, 4'b0100, 4'b0000, 1'b1);
    run(2 * FRAME + 5);
    put(16'h0000, 4'b0000, 4'b0000, 1'b1);
    run(2 * FRAME);
    // Blink on digit 0.
    put(16'h1234, 4'b0000, 4'b0001, 1'b0);
    run(5 * FRAME);
    // Load on the frame-wrap edge is shown on the very next frame.
    while ((e + 1) % FRAME != 0) run(1);
    put(16'habcd, 4'b1001, 4'b0000, 1'b0);
    run(FRAME);
    // Mid-frame load holds until the next wrap.
    run(10);
    put(16'hef98, 4'b0000, 4'b0000, 1'b0);
    run(2 * FRAME);
    mid_reset();
    for (int i = 0; i < 30 * FRAME; i++) begin
      drive_random();
      tick();
    end
    load = 1'b0;
    mid_reset();
    for (int i = 0; i < 8 * FRAME; i++) begin
      drive_random();
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
